// File: rtl/reg_out_pipe.sv
// rtl/reg_out_pipe.sv - output register delay line feeding a small output FIFO
module reg_out_pipe #(
    parameter int DATA_W     = 16,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                stalled_in,
    input  logic                                dataoutv_in,
    input  logic [DATA_W-1:0]                   dataout_in,
    input  logic                                flush,
    input  logic                                out_ready,
    output logic                                stalled_out,
    output logic                                dataoutv_out,
    output logic [DATA_W-1:0]                   dataout_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
    output logic                                overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [LAT-1:0]    stall_q, stall_d;
    logic [LAT-1:0]    vld_q, vld_d;
    logic [DATA_W-1:0] data_q [LAT];
    logic [DATA_W-1:0] data_d [LAT];

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;

    logic empty, full, push, pop, wr_en;

    // Stall bits keep shifting through a flush; only valid bits are killed.
    always_comb begin
        stall_d[0] = stalled_in;
        vld_d[0]   = dataoutv_in & ~flush;
        data_d[0]  = dataout_in;
        for (int i = 1; i < LAT; i++) begin
            stall_d[i] = stall_q[i-1];
            vld_d[i]   = vld_q[i-1] & ~flush;
            data_d[i]  = data_q[i-1];
        end
    end

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(FIFO_DEPTH));
        push     = vld_q[LAT-1] & ~flush;
        pop      = ~empty & out_ready & ~flush;
        wr_en    = push & (~full | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            if (wr_en && !pop)      count_d = count_q + CW'(1);
            else if (!wr_en && pop) count_d = count_q - CW'(1);
            if (push && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q  <= '0;
            vld_q    <= '0;
            for (int i = 0; i < LAT; i++) data_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            stall_q  <= stall_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is left unreset; the empty check below masks stale contents.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr_q] <= data_q[LAT-1];
    end

    assign stalled_out  = stall_q[LAT-1];
    assign dataoutv_out = ~empty;
    assign dataout_out  = empty ? '0 : mem[rd_ptr_q];
    assign fifo_count   = count_q;
    assign overflow     = ovf_q;
endmodule

// File: doc/reg_out_pipe.md
REG_OUT_PIPE -- requirements
Module: reg_out_pipe

Interface
REQ-001 Parameter DATA_W, default 16, width of dataout path in bits (>=1).
REQ-002 Parameter LAT, default 1, number of delay stages for stalled and data/valid (>=1).
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-004 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 stalled_in  input  1  pipeline stall flag from core.
REQ-008 dataoutv_in  input  1  core output-data valid.
REQ-009 dataout_in  input  DATA_W  core output data.
REQ-010 flush  input  1  synchronous discard of all buffered/in-flight data.
REQ-011 out_ready  input  1  downstream accepts head word this cycle.
REQ-012 stalled_out  output  1  stalled_in delayed LAT cycles.
REQ-013 dataoutv_out  output  1  FIFO non-empty; head word valid.
REQ-014 dataout_out  output  DATA_W  FIFO head word.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH+1)  occupied entries.
REQ-016 overflow  output  1  sticky: a word was dropped on full FIFO.

Function
REQ-017 Delay line SHALL be LAT register stages carrying {stalled, valid, data}; stage 1 samples inputs on each rising edge, no enable.
REQ-018 stalled_out SHALL equal stalled_in sampled LAT edges earlier; unaffected by FIFO state, out_ready, or flush.
REQ-019 Data in a stage with valid=0 SHALL be don't-care for push; only final-stage valid=1 words push.
REQ-020 Final-stage valid word SHALL be written into FIFO on the next edge; FIFO empty, LAT=1: dataoutv_in high in cycle t -> dataoutv_out high in cycle t+2 with that word.
REQ-021 Pop SHALL occur on an edge where dataoutv_out=1 and out_ready=1; out_ready ignored when empty.
REQ-022 Order SHALL be strict FIFO; dataout_out SHALL hold stable while dataoutv_out=1 and out_ready=0.
REQ-023 Push and pop same edge: count unchanged, including when full (push accepted because pop frees an entry).
REQ-024 Push when full without pop: word dropped, FIFO unchanged, overflow set to 1 on that edge.
REQ-025 overflow SHALL stay 1 until reset; flush does not clear it.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from fifo_count (0 = empty, FIFO_DEPTH = full).
REQ-027 flush=1 on an edge: all delay-stage valid bits cleared, FIFO emptied (count 0), any same-edge push and pop discarded; stalled delay bits still shift normally.
REQ-028 flush takes priority over push, pop and overflow detection on the same edge.
REQ-029 fifo_count SHALL never exceed FIFO_DEPTH nor underflow below 0.

Reset
REQ-030 reset_n=0 SHALL immediately clear all delay stages (stalled, valid, data to 0), FIFO pointers, fifo_count, overflow; stalled_out=0, dataoutv_out=0, dataout_out=0 while in reset.
REQ-031 Reset mid-operation SHALL discard all in-flight and buffered words; first edge after deassertion behaves as from empty.
REQ-032 FIFO storage array need not be reset; dataout_out SHALL read 0 whenever FIFO empty.

Verification
REQ-033 LAT=1, out_ready=1, dataoutv_in=1 with data 0x0001..0x0005 on consecutive cycles -> dataoutv_out high from t+2, same sequence, one per cycle, count never >1.
REQ-034 LAT=3, stalled_in pulsed one cycle at t -> stalled_out high only in cycle t+3.
REQ-035 FIFO_DEPTH=4, out_ready=0, push 6 words A..F -> count 4, overflow=1 after E, head A; then out_ready=1 -> outputs A,B,C,D, then empty.
REQ-036 Full FIFO, out_ready=1 and new push same cycle -> count stays 4, no overflow, new word appended after existing three.
REQ-037 3 words buffered plus 1 in delay line, flush pulse -> next cycle count 0, dataoutv_out=0, in-flight word never emitted, overflow unchanged.
REQ-038 reset_n low asynchronously mid-burst (between edges) -> outputs and count 0 immediately; after release, new word emerges at normal latency.
